absmem_nw: RTL and testbench

- Parametrised successor of the 1R1W, depth-1 abstract memory used by refinement-check wrappers.
- Holds NE recorded-write entries per side (implementation "vlg" side, specification "ila" side) over a shared, never-written symbolic base array.
- After `compare` rises, reports whether both sides' write sets are consistent.
- Adds same-address write coalescing and sticky overflow detection.
- Instantiated in generated wrappers between the design under test and the ILA model.

---
 rtl/absmem_nw.sv | 183 ++++++++++++++++++
 tb/tb_absmem_nw.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/absmem_nw.sv
// absmem_nw: NE-entry abstract memory pair (vlg/ila) over a shared symbolic base.
// Ports: clk, rst (sync, active-high), issue, compare, vlg_*/ila_* read and write
//   channels, equal, vlg_overflow, ila_overflow. Option: ABSMEM_RD_FWD_EN.
module absmem_nw #(
  parameter int AW  = 8,
  parameter int DW  = 8,
  parameter int NE  = 4,
  parameter int TTS = 256
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          issue,
  input  logic          compare,
  input  logic [AW-1:0] vlg_raddr,
  input  logic          vlg_ren,
  output logic [DW-1:0] vlg_rdata,
  input  logic [DW-1:0] vlg_r_rand_input,
  input  logic [AW-1:0] vlg_waddr,
  input  logic [DW-1:0] vlg_wdata,
  input  logic          vlg_wen,
  input  logic [AW-1:0] ila_raddr,
  input  logic          ila_ren,
  output logic [DW-1:0] ila_rdata,
  input  logic [DW-1:0] ila_r_rand_input,
  input  logic [AW-1:0] ila_waddr,
  input  logic [DW-1:0] ila_wdata,
  input  logic          ila_wen,
  output logic          equal,
  output logic          vlg_overflow,
  output logic          ila_overflow
);

  localparam int CW = $clog2(NE + 1);

  // Side 0 is vlg, side 1 is ila.
  logic          start_and_on;
  logic [DW-1:0] base [TTS];
  logic [AW-1:0] ea   [2][NE];
  logic [DW-1:0] ed   [2][NE];
  logic          ev   [2][NE];
  logic [CW-1:0] cnt  [2];
  logic          ovf  [2];

  logic [AW-1:0] raddr [2];
  logic [AW-1:0] waddr [2];
  logic [DW-1:0] wdata [2];
  logic [DW-1:0] rrand [2];
  logic [DW-1:0] rdata [2];
  logic          ren_r [2];
  logic          wen_r [2];
  logic          upd   [2][NE];
  logic          drop  [2];
  logic          side_ok [2];

  assign raddr[0] = vlg_raddr;
  assign raddr[1] = ila_raddr;
  assign waddr[0] = vlg_waddr;
  assign waddr[1] = ila_waddr;
  assign wdata[0] = vlg_wdata;
  assign wdata[1] = ila_wdata;
  assign rrand[0] = vlg_r_rand_input;
  assign rrand[1] = ila_r_rand_input;

  assign ren_r[0] = vlg_ren & ~compare & start_and_on;
  assign ren_r[1] = ila_ren & ~compare & start_and_on;
  assign wen_r[0] = vlg_wen & ~compare & start_and_on;
  assign wen_r[1] = ila_wen & ~compare & start_and_on;

  // Symbolic initial state: held forever, never loaded.
  always_ff @(posedge clk) begin
    base <= base;
  end

  // Write steering: coalesce on a hit, else fill the next free slot,
  // else drop and flag overflow.
  always_comb begin
    logic hit;
    logic room;
    for (int s = 0; s < 2; s++) begin
      hit     = 1'b0;
      room    = cnt[s] < CW'(NE);
      drop[s] = 1'b0;
      for (int i = 0; i < NE; i++) begin
        if (ev[s][i] && ea[s][i] == waddr[s])
          hit = 1'b1;
      end
      for (int i = 0; i < NE; i++) begin
        upd[s][i] = wen_r[s] &
          ((ev[s][i] && ea[s][i] == waddr[s]) |
           (~hit & room & (cnt[s] == CW'(i))));
      end
      drop[s] = wen_r[s] & ~hit & ~room;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      start_and_on <= 1'b0;
      for (int s = 0; s < 2; s++) begin
        cnt[s] <= '0;
        ovf[s] <= 1'b0;
        for (int i = 0; i < NE; i++)
          ev[s][i] <= 1'b0;
      end
    end else begin
      if (issue)
        start_and_on <= 1'b1;
      for (int s = 0; s < 2; s++) begin
        if (drop[s])
          ovf[s] <= 1'b1;
        for (int i = 0; i < NE; i++) begin
          if (upd[s][i] && !ev[s][i]) begin
            ev[s][i] <= 1'b1;
            cnt[s]   <= cnt[s] + 1'b1;
          end
        end
      end
    end
  end

  // Entry payload carries no reset; validity alone qualifies it.
  always_ff @(posedge clk) begin
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < NE; i++) begin
        if (upd[s][i]) begin
          ea[s][i] <= waddr[s];
          ed[s][i] <= wdata[s];
        end
      end
    end
  end

  // Reads see pre-write state unless forwarding is compiled in.
  always_comb begin
    for (int s = 0; s < 2; s++) begin
      rdata[s] = rrand[s];
      if (ren_r[s]) begin
        rdata[s] = base[raddr[s]];
        for (int i = 0; i < NE; i++) begin
          if (ev[s][i] && ea[s][i] == raddr[s])
            rdata[s] = ed[s][i];
        end
`ifdef ABSMEM_RD_FWD_EN
        if (wen_r[s] && waddr[s] == raddr[s])
          rdata[s] = wdata[s];
`endif
      end
    end
  end

  // A recorded write must agree with the other side's write to the same
  // address, or with the base value when the other side never wrote it.
  always_comb begin
    logic found;
    logic ok;
    int   o;
    for (int s = 0; s < 2; s++) begin
      o = 1 - s;
      side_ok[s] = 1'b1;
      for (int i = 0; i < NE; i++) begin
        found = 1'b0;
        ok    = 1'b1;
        for (int j = 0; j < NE; j++) begin
          if (ev[o][j] && ea[o][j] == ea[s][i]) begin
            found = 1'b1;
            ok    = ed[o][j] == ed[s][i];
          end
        end
        if (!found)
          ok = ed[s][i] == base[ea[s][i]];
        if (ev[s][i] && !ok)
          side_ok[s] = 1'b0;
      end
    end
  end

  assign vlg_rdata    = rdata[0];
  assign ila_rdata    = rdata[1];
  assign vlg_overflow = ovf[0];
  assign ila_overflow = ovf[1];
  assign equal = compare & side_ok[0] & side_ok[1] & ~ovf[0] & ~ovf[1];

endmodule

// File: tb/tb_absmem_nw.sv
// tb_absmem_nw: directed checks of absmem_nw recording, reads,
// coalescing, overflow, freeze and reset.
module tb_absmem_nw;

  logic       clk = 1'b0;
  logic       rst, issue, compare;
  logic [7:0] vlg_raddr, vlg_rdata, vlg_r_rand_input;
  logic [7:0] vlg_waddr, vlg_wdata;
  logic       vlg_ren, vlg_wen;
  logic [7:0] ila_raddr, ila_rdata, ila_r_rand_input;
  logic [7:0] ila_waddr, ila_wdata;
  logic       ila_ren, ila_wen;
  logic       equal, vlg_overflow, ila_overflow;
  logic [7:0] b;
  int         n_chk = 0;
  int         n_fail = 0;

  always #5 clk = ~clk;

  absmem_nw dut (
    .clk(clk), .rst(rst), .issue(issue), .compare(compare),
    .vlg_raddr(vlg_raddr), .vlg_ren(vlg_ren), .vlg_rdata(vlg_rdata),
    .vlg_r_rand_input(vlg_r_rand_input),
    .vlg_waddr(vlg_waddr), .vlg_wdata(vlg_wdata), .vlg_wen(vlg_wen),
    .ila_raddr(ila_raddr), .ila_ren(ila_ren), .ila_rdata(ila_rdata),
    .ila_r_rand_input(ila_r_rand_input),
    .ila_waddr(ila_waddr), .ila_wdata(ila_wdata), .ila_wen(ila_wen),
    .equal(equal), .vlg_overflow(vlg_overflow),
    .ila_overflow(ila_overflow)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic vw(input logic [7:0] a, input logic [7:0] d);
    vlg_wen = 1'b1; vlg_waddr = a; vlg_wdata = d;
    tick();
    vlg_wen = 1'b0;
  endtask

  task automatic iw(input logic [7:0] a, input logic [7:0] d);
    ila_wen = 1'b1; ila_waddr = a; ila_wdata = d;
    tick();
    ila_wen = 1'b0;
  endtask

  task automatic cmp(input string tag, input logic exp);
    compare = 1'b1;
    #1;
    chk(tag, equal, exp);
    compare = 1'b0;
  endtask

  initial begin
    rst = 1'b1; issue = 1'b0; compare = 1'b0;
    vlg_raddr = '0; vlg_ren = 1'b0; vlg_r_rand_input = 8'h5A;
    vlg_waddr = '0; vlg_wdata = '0; vlg_wen = 1'b0;
    ila_raddr = '0; ila_ren = 1'b0; ila_r_rand_input = 8'hA5;
    ila_waddr = '0; ila_wdata = '0; ila_wen = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_vovf", vlg_overflow, 0);
    chk("rst_iovf", ila_overflow, 0);
    chk("rst_eq_nocmp", equal, 0);
    cmp("rst_eq_cmp", 1'b1);

    // Write in the issue cycle is ignored.
    issue = 1'b1;
    vw(8'h33, 8'h11);
    issue = 1'b0;
    cmp("issue_wr_ignored", 1'b1);
    vlg_ren = 1'b1; vlg_raddr = 8'h33;
    ila_ren = 1'b1; ila_raddr = 8'h33;
    #1;
    chk("issue_wr_rd", vlg_rdata, ila_rdata);
    vlg_ren = 1'b0; ila_ren = 1'b0;
    #1;
    chk("rand_vlg", vlg_rdata, 8'h5A);
    chk("rand_ila", ila_rdata, 8'hA5);
    tick();

    // Matching writes on both sides.
    vlg_wen = 1'b1; vlg_waddr = 8'h10; vlg_wdata = 8'hAA;
    iw(8'h10, 8'hAA);
    vlg_wen = 1'b0;
    cmp("match_eq", 1'b1);
    chk("match_vovf", vlg_overflow, 0);
    chk("match_iovf", ila_overflow, 0);

    // Writes under compare are frozen out.
    compare = 1'b1;
    vw(8'h10, 8'h55);
    compare = 1'b0;
    cmp("frozen_eq", 1'b1);
    vlg_ren = 1'b1; vlg_raddr = 8'h10;
    #1;
    chk("frozen_rd", vlg_rdata, 8'hAA);
    vlg_ren = 1'b0;
    tick();

    // Recorded data read-back and base fallthrough.
    vw(8'h20, 8'h05);
    vlg_ren = 1'b1; vlg_raddr = 8'h20;
    #1;
    chk("rd_hit", vlg_rdata, 8'h05);
    vlg_raddr = 8'h21; ila_ren = 1'b1; ila_raddr = 8'h21;
    #1;
    chk("rd_base", vlg_rdata, ila_rdata);
    ila_ren = 1'b0;
    tick();

    // Same-cycle write and read of one address.
    vlg_raddr = 8'h20;
    vlg_wen = 1'b1; vlg_waddr = 8'h20; vlg_wdata = 8'h06;
    #1;
`ifdef ABSMEM_RD_FWD_EN
    chk("rw_same", vlg_rdata, 8'h06);
`else
    chk("rw_same", vlg_rdata, 8'h05);
`endif
    tick();
    vlg_wen = 1'b0;
    #1;
    chk("rw_after", vlg_rdata, 8'h06);
    vlg_ren = 1'b0;
    tick();

    // Data mismatch, then coalesced fix on the ila side.
    iw(8'h20, 8'h07);
    cmp("mismatch_eq", 1'b0);
    iw(8'h20, 8'h06);
    cmp("coalesce_eq", 1'b1);

    // One-sided write checked against base.
    vlg_ren = 1'b1; vlg_raddr = 8'h50;
    #1;
    b = vlg_rdata;
    vlg_ren = 1'b0;
    tick();
    vw(8'h50, b);
    cmp("base_eq", 1'b1);
    vw(8'h50, b ^ 8'h01);
    cmp("base_ne", 1'b0);
    vw(8'h50, b);
    cmp("base_eq2", 1'b1);

    // Fill to NE, coalesce, then overflow.
    vw(8'h60, 8'h01);
    chk("full_vovf", vlg_overflow, 0);
    vw(8'h10, 8'hAA);
    chk("coal_vovf", vlg_overflow, 0);
    vw(8'h70, 8'h02);
    chk("ovf_vovf", vlg_overflow, 1);
    chk("ovf_iovf", ila_overflow, 0);
    cmp("ovf_eq", 1'b0);
    vlg_ren = 1'b1; vlg_raddr = 8'h70;
    ila_ren = 1'b1; ila_raddr = 8'h70;
    #1;
    chk("drop_rd", vlg_rdata, ila_rdata);
    vlg_ren = 1'b0; ila_ren = 1'b0;
    tick();

    // Reset mid-operation.
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst2_vovf", vlg_overflow, 0);
    cmp("rst2_eq", 1'b1);
    vw(8'h10, 8'h99);
    cmp("rst2_start_off", 1'b1);
    issue = 1'b1;
    tick();
    issue = 1'b0;

    vlg_ren = 1'b1; vlg_raddr = 8'h30;
    ila_ren = 1'b1; ila_raddr = 8'h30;
    vlg_wen = 1'b1; vlg_waddr = 8'h30; vlg_wdata = 8'h77;
    #1;
`ifdef ABSMEM_RD_FWD_EN
    chk("fwd_rd", vlg_rdata, 8'h77);
`else
    chk("fwd_rd", vlg_rdata, ila_rdata);
`endif
    tick();
    vlg_wen = 1'b0; vlg_ren = 1'b0; ila_ren = 1'b0;

    // ila side overflow.
    iw(8'h30, 8'h77);
    iw(8'h01, 8'h00);
    iw(8'h02, 8'h00);
    iw(8'h03, 8'h00);
    chk("ila_full", ila_overflow, 0);
    iw(8'h04, 8'h00);
    chk("ila_ovf", ila_overflow, 1);
    chk("ila_ovf_v", vlg_overflow, 0);
    cmp("ila_ovf_eq", 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule
